// File: rtl/sort_pair_ser_gen_if.sv
// Sorted-pair serial link, transmit-side bundle.
// Upstream operand handshake: in_valid, in_ready, a, b.
// Serial line plus framing strobes: ser_out, ser_vld, sof, eof, swapped.
// master: upstream / observer side.  slave: the transmitter.
interface sort_pair_ser_gen_if;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] a;
    logic [1:0] b;
    logic       ser_out;
    logic       ser_vld;
    logic       sof;
    logic       eof;
    logic       swapped;

    modport master (
        output in_valid, a, b,
        input  in_ready, ser_out, ser_vld, sof, eof, swapped
    );

    modport slave (
        input  in_valid, a, b,
        output in_ready, ser_out, ser_vld, sof, eof, swapped
    );
endinterface

// File: rtl/sort_pair_ser_gen.sv
// Sorted-pair serial transmitter.
// Accepts an operand pair (a, b) on a valid/ready handshake, orders it by
// ORDER (0 = ascending, 1 = descending) into a 4-bit word {hi, lo}, and
// sends that word MSB first, one bit per clock, with sof/eof strobes.
// GAP idle cycles follow each frame before in_ready reasserts.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - slave side of sort_pair_ser_gen_if (handshake in, serial out)
module sort_pair_ser_gen #(
    parameter bit          ORDER = 1'b0,
    parameter int unsigned GAP   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    sort_pair_ser_gen_if.slave    bus
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SORT,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t             state_q;
    logic [1:0]         a_q;
    logic [1:0]         b_q;
    logic [2:0]         shift_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [CNT_W-1:0]   gap_cnt_q;
    logic               in_ready_q;
    logic               ser_out_q;
    logic               ser_vld_q;
    logic               sof_q;
    logic               eof_q;
    logic               swapped_q;

    logic [1:0]         min_c;
    logic [1:0]         max_c;
    logic [3:0]         word_c;
    logic               swap_c;

    // Unsigned ordering of the captured pair; swap is flagged only when the
    // ordered word differs from the arrival order (equal operands never swap).
    always_comb begin
        min_c  = a_q;
        max_c  = b_q;
        if (a_q > b_q) begin
            min_c = b_q;
            max_c = a_q;
        end
        word_c = ORDER ? {max_c, min_c} : {min_c, max_c};
        swap_c = (word_c != {a_q, b_q});
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            a_q        <= 2'b00;
            b_q        <= 2'b00;
            shift_q    <= 3'b000;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            in_ready_q <= 1'b1;
            ser_out_q  <= 1'b0;
            ser_vld_q  <= 1'b0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            swapped_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_SORT;
                    end
                end
                ST_SORT: begin
                    ser_out_q <= word_c[3];
                    shift_q   <= word_c[2:0];
                    ser_vld_q <= 1'b1;
                    sof_q     <= 1'b1;
                    swapped_q <= swap_c;
                    bit_cnt_q <= CNT_W'(1);
                    state_q   <= ST_SEND;
                end
                ST_SEND: begin
                    sof_q <= 1'b0;
                    if (bit_cnt_q == CNT_W'(4)) begin
                        // Frame done: one edge to drop the line, then gap or idle.
                        ser_vld_q <= 1'b0;
                        eof_q     <= 1'b0;
                        ser_out_q <= 1'b0;
                        bit_cnt_q <= '0;
                        gap_cnt_q <= '0;
                        if (GAP == 0) begin
                            in_ready_q <= 1'b1;
                            state_q    <= ST_IDLE;
                        end else begin
                            state_q    <= ST_GAP;
                        end
                    end else begin
                        ser_out_q <= shift_q[2];
                        shift_q   <= {shift_q[1:0], 1'b0};
                        eof_q     <= (bit_cnt_q == CNT_W'(3));
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (32'(gap_cnt_q) + 32'd1 >= GAP) begin
                        gap_cnt_q  <= '0;
                        in_ready_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end else begin
                        gap_cnt_q  <= gap_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.ser_out  = ser_out_q;
    assign bus.ser_vld  = ser_vld_q;
    assign bus.sof      = sof_q;
    assign bus.eof      = eof_q;
    assign bus.swapped  = swapped_q;

endmodule

// File: tb/tb_sort_pair_ser_gen.sv
// Bench for sort_pair_ser_gen: three instances (ascending GAP=1,
// descending GAP=1, ascending GAP=0) share clk/rst.  Frames are checked
// cycle by cycle against a table and a sort-based reference model, and a
// line monitor collects every completed frame for spacing checks.
module tb_sort_pair_ser_gen;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sort_pair_ser_gen_if ifc0 ();
    sort_pair_ser_gen_if ifc1 ();
    sort_pair_ser_gen_if ifc2 ();

    sort_pair_ser_gen #(.ORDER(1'b0), .GAP(1)) u_asc  (.clk(clk), .rst(rst), .bus(ifc0));
    sort_pair_ser_gen #(.ORDER(1'b1), .GAP(1)) u_desc (.clk(clk), .rst(rst), .bus(ifc1));
    sort_pair_ser_gen #(.ORDER(1'b0), .GAP(0)) u_nogap(.clk(clk), .rst(rst), .bus(ifc2));

    logic       vld_r [3];
    logic [1:0] a_r   [3];
    logic [1:0] b_r   [3];
    logic [5:0] obs   [3];   // {in_ready, ser_vld, ser_out, sof, eof, swapped}

    assign ifc0.in_valid = vld_r[0];
    assign ifc0.a        = a_r[0];
    assign ifc0.b        = b_r[0];
    assign ifc1.in_valid = vld_r[1];
    assign ifc1.a        = a_r[1];
    assign ifc1.b        = b_r[1];
    assign ifc2.in_valid = vld_r[2];
    assign ifc2.a        = a_r[2];
    assign ifc2.b        = b_r[2];
    assign obs[0] = {ifc0.in_ready, ifc0.ser_vld, ifc0.ser_out, ifc0.sof, ifc0.eof, ifc0.swapped};
    assign obs[1] = {ifc1.in_ready, ifc1.ser_vld, ifc1.ser_out, ifc1.sof, ifc1.eof, ifc1.swapped};
    assign obs[2] = {ifc2.in_ready, ifc2.ser_vld, ifc2.ser_out, ifc2.sof, ifc2.eof, ifc2.swapped};

    int gap_of [3] = '{1, 1, 0};
    bit ord_of [3] = '{1'b0, 1'b1, 1'b0};
    logic prev_sw [3] = '{1'b0, 1'b0, 1'b0};

    int n_chk  = 0;
    int n_fail = 0;

    // ---------------- line monitor ----------------
    int         cyc = 0;
    logic [3:0] acc       [3] = '{4'h0, 4'h0, 4'h0};
    int         len       [3] = '{0, 0, 0};
    int         cur_sof   [3] = '{0, 0, 0};
    int         mon_n     [3] = '{0, 0, 0};
    int         eof_cnt   [3] = '{0, 0, 0};
    logic [3:0] mon_word  [3][64];
    int         mon_sof   [3][64];
    int         mon_len   [3][64];

    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                len[k] = 0;
            end else if (obs[k][4]) begin
                acc[k] = {acc[k][2:0], obs[k][3]};
                if (obs[k][2]) begin
                    len[k]     = 1;
                    cur_sof[k] = cyc;
                end else begin
                    len[k] = len[k] + 1;
                end
                if (obs[k][1]) begin
                    eof_cnt[k] = eof_cnt[k] + 1;
                    if (mon_n[k] < 64) begin
                        mon_word[k][mon_n[k]] = acc[k];
                        mon_sof[k][mon_n[k]]  = cur_sof[k];
                        mon_len[k][mon_n[k]]  = len[k];
                    end
                    mon_n[k] = mon_n[k] + 1;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // Sort the two operands as a list, then concatenate in the requested order.
    function automatic logic [3:0] model_word(input bit ord, input logic [1:0] x, input logic [1:0] y);
        int v [2];
        int t;
        v[0] = int'(x);
        v[1] = int'(y);
        if (v[0] > v[1]) begin
            t    = v[0];
            v[0] = v[1];
            v[1] = t;
        end
        if (ord) return {2'(v[1]), 2'(v[0])};
        return {2'(v[0]), 2'(v[1])};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic wait_ready(input int k, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (obs[k][5] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk($sformatf("ready_timeout k%0d", k), 32'd0, 32'd1);
    endtask

    // One pair through instance k, checking every output each cycle until
    // in_ready returns.  With inject set, a second pair is offered mid-frame.
    task automatic send(input int k, input logic [1:0] av, input logic [1:0] bv,
                        input logic [3:0] ew, input logic esw, input bit inject);
        bit ok;
        int base;
        logic [5:0] e;
        wait_ready(k, ok);
        if (!ok) return;
        base     = mon_n[k];
        vld_r[k] = 1'b1;
        a_r[k]   = av;
        b_r[k]   = bv;
        @(posedge clk);
        #1;
        vld_r[k] = 1'b0;
        a_r[k]   = 2'($urandom);
        b_r[k]   = 2'($urandom);
        for (int j = 0; j <= 5 + gap_of[k]; j++) begin
            @(negedge clk);
            e[5] = (j >= 5 + gap_of[k]);
            e[4] = (j >= 1 && j <= 4);
            e[3] = (j >= 1 && j <= 4) ? ew[4 - j] : 1'b0;
            e[2] = (j == 1);
            e[1] = (j == 4);
            e[0] = (j == 0) ? prev_sw[k] : esw;
            chk($sformatf("frame k%0d a%0d b%0d cyc%0d {rdy,vld,out,sof,eof,sw}", k, av, bv, j),
                32'(obs[k]), 32'(e));
            if (inject && j == 2) begin
                vld_r[k] = 1'b1;
                a_r[k]   = 2'd0;
                b_r[k]   = 2'd1;
            end
            if (inject && j == 3) vld_r[k] = 1'b0;
        end
        prev_sw[k] = esw;
        if (inject) begin
            repeat (8) @(negedge clk);
            chk($sformatf("inject_frame_count k%0d", k), 32'(mon_n[k] - base), 32'd1);
            chk($sformatf("inject_still_ready k%0d", k), 32'(obs[k][5]), 32'd1);
        end
    endtask

    // Stream n pairs with in_valid held high; check words and sof spacing.
    logic [1:0] st_a [16];
    logic [1:0] st_b [16];

    task automatic stream(input int k, input int n);
        bit ok;
        int base;
        int idx;
        base = mon_n[k];
        for (int i = 0; i < n; i++) begin
            wait_ready(k, ok);
            if (!ok) break;
            vld_r[k] = 1'b1;
            a_r[k]   = st_a[i];
            b_r[k]   = st_b[i];
            @(posedge clk);
            #1;
        end
        vld_r[k] = 1'b0;
        repeat (10 + gap_of[k]) @(negedge clk);
        #1;
        chk($sformatf("stream_count k%0d", k), 32'(mon_n[k] - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            idx = base + i;
            if (idx >= 64 || idx >= mon_n[k]) break;
            chk($sformatf("stream_word k%0d i%0d", k, i), 32'(mon_word[k][idx]),
                32'(model_word(ord_of[k], st_a[i], st_b[i])));
            chk($sformatf("stream_len k%0d i%0d", k, i), 32'(mon_len[k][idx]), 32'd4);
            if (i > 0)
                chk($sformatf("stream_spacing k%0d i%0d", k, i),
                    32'(mon_sof[k][idx] - mon_sof[k][idx - 1]), 32'(6 + gap_of[k]));
        end
        prev_sw[k] = (model_word(ord_of[k], st_a[n - 1], st_b[n - 1]) != {st_a[n - 1], st_b[n - 1]});
    endtask

    typedef struct {
        int         k;
        logic [1:0] a;
        logic [1:0] b;
        logic [3:0] w;
        logic       sw;
        bit         inject;
    } vec_t;

    vec_t tbl [9];

    initial begin
        bit ok;
        int e0;
        int k;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [3:0] rw;

        tbl[0] = '{k: 0, a: 2'd3, b: 2'd2, w: 4'b1011, sw: 1'b1, inject: 1'b0};
        tbl[1] = '{k: 0, a: 2'd1, b: 2'd2, w: 4'b0110, sw: 1'b0, inject: 1'b0};
        tbl[2] = '{k: 0, a: 2'd2, b: 2'd2, w: 4'b1010, sw: 1'b0, inject: 1'b0};
        tbl[3] = '{k: 0, a: 2'd3, b: 2'd0, w: 4'b0011, sw: 1'b1, inject: 1'b1};
        tbl[4] = '{k: 1, a: 2'd0, b: 2'd3, w: 4'b1100, sw: 1'b1, inject: 1'b0};
        tbl[5] = '{k: 1, a: 2'd3, b: 2'd1, w: 4'b1101, sw: 1'b0, inject: 1'b0};
        tbl[6] = '{k: 1, a: 2'd1, b: 2'd1, w: 4'b0101, sw: 1'b0, inject: 1'b0};
        tbl[7] = '{k: 2, a: 2'd2, b: 2'd0, w: 4'b0010, sw: 1'b1, inject: 1'b0};
        tbl[8] = '{k: 2, a: 2'd0, b: 2'd0, w: 4'b0000, sw: 1'b0, inject: 1'b0};

        for (int i = 0; i < 3; i++) begin
            vld_r[i] = 1'b0;
            a_r[i]   = 2'd0;
            b_r[i]   = 2'd0;
        end

        // Reset values on every instance.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk($sformatf("reset k%0d {rdy,vld,out,sof,eof,sw}", i), 32'(obs[i]), 32'(6'b100000));
        rst = 1'b0;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 9; i++)
            send(tbl[i].k, tbl[i].a, tbl[i].b, tbl[i].w, tbl[i].sw, tbl[i].inject);

        // Held in_valid: spacing 7 at GAP=1, 6 at GAP=0.
        st_a[0] = 2'd1; st_b[0] = 2'd2;
        st_a[1] = 2'd2; st_b[1] = 2'd2;
        st_a[2] = 2'd3; st_b[2] = 2'd1;
        st_a[3] = 2'd0; st_b[3] = 2'd0;
        stream(0, 4);
        for (int i = 0; i < 16; i++) begin
            st_a[i] = 2'(i / 4);
            st_b[i] = 2'(i % 4);
        end
        stream(2, 16);
        for (int i = 0; i < 5; i++) begin
            st_a[i] = 2'($urandom);
            st_b[i] = 2'($urandom);
        end
        stream(1, 5);

        // Reset in the middle of a frame: abandoned, no eof, then a clean frame.
        wait_ready(0, ok);
        if (ok) begin
            e0       = eof_cnt[0];
            vld_r[0] = 1'b1;
            a_r[0]   = 2'd3;
            b_r[0]   = 2'd2;
            @(posedge clk);
            #1;
            vld_r[0] = 1'b0;
            repeat (3) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("midframe_reset {rdy,vld,out,sof,eof,sw}", 32'(obs[0]), 32'(6'b100000));
            for (int j = 0; j < 6; j++) begin
                @(negedge clk);
                chk($sformatf("post_reset_idle cyc%0d", j), 32'(obs[0]), 32'(6'b100000));
            end
            chk("post_reset_no_eof", 32'(eof_cnt[0] - e0), 32'd0);
            for (int i = 0; i < 3; i++) prev_sw[i] = 1'b0;
            send(0, 2'd2, 2'd1, 4'b0110, 1'b1, 1'b0);
        end

        // Random pairs against the model.
        for (int i = 0; i < 30; i++) begin
            k  = int'($urandom_range(0, 2));
            ra = 2'($urandom);
            rb = 2'($urandom);
            rw = model_word(ord_of[k], ra, rb);
            send(k, ra, rb, rw, (rw != {ra, rb}), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sort_pair_ser_gen.md
Name: sort_pair_ser_gen

Overview:
Transmit side of the sorted-pair serial link. Accepts two 2-bit operands over a valid/ready handshake and orders them by the ORDER parameter. Serialises the ordered pair as one 4-bit frame, MSB first, one bit per clock. Drives the serial line that the sorted-pair detector samples, and adds framing strobes for bench and link alignment.

Parameters:
ORDER, 0, 0 = ascending (smaller operand in frame bits [3:2]), 1 = descending
GAP, 1, idle cycles (ser_vld=0, ser_out=0) inserted after each frame before in_ready reasserts; legal range 0..7

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept a pair (registered)
a  input  2  operand A
b  input  2  operand B
ser_out  output  1  serial frame bit, MSB first (registered)
ser_vld  output  1  ser_out carries a frame bit (registered)
sof  output  1  high with frame bit 3
eof  output  1  high with frame bit 0
swapped  output  1  operands were exchanged to meet ORDER; held from sof until the next sof

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All outputs are registered.
- Reset values: in_ready=1, ser_out=0, ser_vld=0, sof=0, eof=0, swapped=0, state=IDLE, bit counter=0, gap counter=0.
- A handshake occurs at a rising edge where in_valid=1 and in_ready=1. a and b are captured at that edge.
- States: IDLE, SORT, SEND, GAP.
- IDLE: in_ready=1; a handshake moves to SORT and clears in_ready.
- SORT (1 cycle): build word W = {hi, lo}.
  - ORDER=0: hi=min(a,b), lo=max(a,b).
  - ORDER=1: hi=max(a,b), lo=min(a,b).
  - swapped <= 1 iff {hi,lo} != {a,b}. Equal operands give swapped=0.
  - At the same edge: ser_out<=W[3], ser_vld<=1, sof<=1. Go to SEND with the bit counter at 1.
- SEND: each edge shifts out the next bit (W[2], then W[1], then W[0]) and clears sof.
  - eof<=1 together with W[0].
  - On the edge after W[0] is driven: ser_vld<=0, eof<=0, ser_out<=0.
  - Then go to GAP if GAP>0, otherwise go to IDLE with in_ready<=1.
- GAP: holds for GAP cycles, then goes to IDLE with in_ready<=1.
- Latency: handshake at edge N → W[3] visible after edge N+1; W[0] visible after edge N+4; ser_vld low after edge N+5.
- Frame length is exactly 4 bit periods with ser_vld=1 continuously. No bubbles.
- Minimum handshake-to-handshake spacing is 6+GAP cycles.
- in_valid while in_ready=0 is ignored. a and b are not sampled and nothing is queued. The upstream must hold in_valid until the handshake.
- in_ready=0 from the handshake edge until IDLE is re-entered. No back-to-back acceptance inside a frame.
- rst asserted mid-frame: at that edge all outputs return to reset values and the partial frame is abandoned (no eof). The next handshake after rst deasserts starts a clean frame.
- rst takes priority over a coincident handshake.
- The 2-bit compare is unsigned. Word assembly is pure bit concatenation with no arithmetic overflow.

Test Plan:
- ORDER=0, a=3, b=2 handshake at edge N → ser_out 1,0,1,1 after edges N+1..N+4; sof with the first bit, eof with the last; swapped=1; ser_vld=0 after N+5; in_ready=1 after N+6 (GAP=1).
- ORDER=0, a=1, b=2 → bits 0,1,1,0; swapped=0. Then a=2, b=2 → bits 1,0,1,0; swapped=0. Frame spacing of exactly 7 cycles with in_valid held high.
- ORDER=1, a=0, b=3 → bits 1,1,0,0; swapped=1.
- in_valid pulses with a=0, b=1 while the frame for a=3, b=0 is in SEND → only 0,0,1,1 is sent; the ignored pair never appears; in_ready stays 0 throughout.
- rst asserted at edge N+3 during a frame → after that edge ser_vld=0, eof never asserts, in_ready=1, swapped=0. A new pair a=2, b=1 then yields 0,1,1,0.
- GAP=0 build, continuous in_valid → frames separated by exactly 2 cycles of ser_vld=0 (return edge plus the SORT cycle). Loopback into the sorted-pair detector: its det output matches the expected pattern for every 2-bit pair combination.
